counter_updn_param: RTL and testbench

Parametrised up/down event counter, successor to the fixed 16-bit Counter. It adds configurable width and terminal value, a selectable step size, wrap or saturate mode, and optional rising-edge qualification of inc for pushbutton-style inputs. It also adds synchronous parallel load, terminal-count pulses and sticky overflow/underflow flags. It drives display and timing logic in the lab top-levels.

---
 rtl/counter_updn_param.sv | 125 ++++++++++++
 tb/tb_counter_updn_param.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_updn_param.sv
`default_nettype none
// ============================================================================
//  Module      : counter_updn_param
//  Description : Parametrised up/down event counter with selectable step,
//                wrap or saturate behaviour, optional rising-edge qualified
//                step input, synchronous parallel load, terminal-count pulse
//                and sticky overflow/underflow flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module counter_updn_param #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter int               STEP     = 1,
    parameter int               SATURATE = 0,
    parameter int               EDGE_INC = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             UPHDNL,
    input  logic             inc,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             at_max,
    output logic             at_min,
    output logic             ovf_sticky,
    output logic             unf_sticky
);

    // All step arithmetic is done one bit wider than the counter so that
    // count + STEP and count + (MAX_VAL+1) can never overflow.
    localparam logic [WIDTH:0] c_max  = {1'b0, MAX_VAL};
    localparam logic [WIDTH:0] c_mod  = c_max + (WIDTH+1)'(1);
    localparam logic [WIDTH:0] c_step = (WIDTH+1)'(STEP);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;
    logic             r_unf;
    logic             r_inc_d;

    logic             w_step;
    logic [WIDTH:0]   w_cur;
    logic [WIDTH:0]   w_up_sum;
    logic             w_up_bnd;
    logic             w_dn_bnd;
    logic [WIDTH-1:0] w_up_next;
    logic [WIDTH-1:0] w_dn_next;
    logic [WIDTH-1:0] w_step_next;
    logic [WIDTH-1:0] w_load_clamp;
    logic             w_set_ovf;
    logic             w_set_unf;

    // Previous value of inc for edge qualification; sampled unconditionally so
    // an inc held high through reset or load does not count as a fresh edge.
    always_ff @(posedge clk) begin
        r_inc_d <= inc;
    end

    // Step qualification, next-count candidates and boundary detection.
    always_comb begin
        w_step       = (EDGE_INC != 0) ? (inc & ~r_inc_d) : inc;
        w_cur        = {1'b0, r_count};
        w_up_sum     = w_cur + c_step;
        w_up_bnd     = (w_up_sum > c_max);
        w_dn_bnd     = (w_cur < c_step);

        w_up_next    = w_up_sum[WIDTH-1:0];
        if (w_up_bnd) begin
            if (SATURATE != 0) begin
                w_up_next = MAX_VAL;
            end else begin
                w_up_next = WIDTH'(w_up_sum - c_mod);
            end
        end

        w_dn_next    = WIDTH'(w_cur - c_step);
        if (w_dn_bnd) begin
            if (SATURATE != 0) begin
                w_dn_next = '0;
            end else begin
                w_dn_next = WIDTH'(w_cur + c_mod - c_step);
            end
        end

        w_step_next  = UPHDNL ? w_up_next : w_dn_next;
        w_set_ovf    = w_step &  UPHDNL & w_up_bnd;
        w_set_unf    = w_step & ~UPHDNL & w_dn_bnd;
        w_load_clamp = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end

    // Count, terminal pulse and sticky flags: reset beats load beats step;
    // a boundary event wins over a coincident clr_flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (load) begin
            r_count <= w_load_clamp;
            r_tc    <= 1'b0;
            r_ovf   <= r_ovf & ~clr_flags;
            r_unf   <= r_unf & ~clr_flags;
        end else begin
            if (w_step) begin
                r_count <= w_step_next;
            end
            r_tc    <= w_set_ovf | w_set_unf;
            r_ovf   <= w_set_ovf | (r_ovf & ~clr_flags);
            r_unf   <= w_set_unf | (r_unf & ~clr_flags);
        end
    end

    assign count      = r_count;
    assign tc         = r_tc;
    assign ovf_sticky = r_ovf;
    assign unf_sticky = r_unf;
    assign at_max     = (r_count == MAX_VAL);
    assign at_min     = (r_count == '0);

endmodule
`default_nettype wire

// File: tb/tb_counter_updn_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_counter_updn_param
//  Description : Self-checking bench for counter_updn_param. Five instances
//                with different configurations share one stimulus stream; an
//                arithmetic reference model feeds a scoreboard queue that an
//                independent monitor drains after every clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_updn_param;

    logic        clk = 1'b0;
    logic        rst, updn, inc, load, clr;
    logic [15:0] lv;

    logic [15:0] cnt_a;
    logic [3:0]  cnt_b, cnt_c, cnt_d, cnt_e;
    logic [4:0]  tc_w, ovf_w, unf_w, amax_w, amin_w;

    int n_checks = 0;
    int n_pass   = 0;

    // Instance configurations: A defaults, B wrap 0..9, C saturate 0..9,
    // D wrap 0..9 step 3, E wrap 0..9 level-qualified inc.
    int unsigned cfg_max  [5] = '{65535, 9, 9, 9, 9};
    int unsigned cfg_step [5] = '{1, 1, 1, 3, 1};
    int unsigned cfg_mask [5] = '{65535, 15, 15, 15, 15};
    bit          cfg_sat  [5] = '{0, 0, 1, 0, 0};
    bit          cfg_edge [5] = '{1, 1, 1, 1, 0};

    int unsigned m_cnt  [5];
    bit          m_tc   [5];
    bit          m_ovf  [5];
    bit          m_unf  [5];
    bit          m_incd [5];

    typedef struct {
        int          idx;
        int unsigned cnt;
        bit          tc, ovf, unf, amax, amin;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    counter_updn_param u_a (
        .clk(clk), .rst(rst), .UPHDNL(updn), .inc(inc), .load(load), .load_val(lv),
        .clr_flags(clr), .count(cnt_a), .tc(tc_w[0]), .at_max(amax_w[0]),
        .at_min(amin_w[0]), .ovf_sticky(ovf_w[0]), .unf_sticky(unf_w[0]));

    counter_updn_param #(.WIDTH(4), .MAX_VAL(4'd9)) u_b (
        .clk(clk), .rst(rst), .UPHDNL(updn), .inc(inc), .load(load), .load_val(lv[3:0]),
        .clr_flags(clr), .count(cnt_b), .tc(tc_w[1]), .at_max(amax_w[1]),
        .at_min(amin_w[1]), .ovf_sticky(ovf_w[1]), .unf_sticky(unf_w[1]));

    counter_updn_param #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1)) u_c (
        .clk(clk), .rst(rst), .UPHDNL(updn), .inc(inc), .load(load), .load_val(lv[3:0]),
        .clr_flags(clr), .count(cnt_c), .tc(tc_w[2]), .at_max(amax_w[2]),
        .at_min(amin_w[2]), .ovf_sticky(ovf_w[2]), .unf_sticky(unf_w[2]));

    counter_updn_param #(.WIDTH(4), .MAX_VAL(4'd9), .STEP(3)) u_d (
        .clk(clk), .rst(rst), .UPHDNL(updn), .inc(inc), .load(load), .load_val(lv[3:0]),
        .clr_flags(clr), .count(cnt_d), .tc(tc_w[3]), .at_max(amax_w[3]),
        .at_min(amin_w[3]), .ovf_sticky(ovf_w[3]), .unf_sticky(unf_w[3]));

    counter_updn_param #(.WIDTH(4), .MAX_VAL(4'd9), .EDGE_INC(0)) u_e (
        .clk(clk), .rst(rst), .UPHDNL(updn), .inc(inc), .load(load), .load_val(lv[3:0]),
        .clr_flags(clr), .count(cnt_e), .tc(tc_w[4]), .at_max(amax_w[4]),
        .at_min(amin_w[4]), .ovf_sticky(ovf_w[4]), .unf_sticky(unf_w[4]));

    // Reference model: advance every configuration by one cycle using the
    // current inputs and queue the expected post-edge outputs.
    task automatic model_and_push();
        for (int k = 0; k < 5; k++) begin
            bit          stp;
            int unsigned mx, st, lvk;
            exp_t        e;
            mx  = cfg_max[k];
            st  = cfg_step[k];
            stp = cfg_edge[k] ? (inc && !m_incd[k]) : inc;
            m_incd[k] = inc;
            if (rst) begin
                m_cnt[k] = 0; m_tc[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
            end else if (load) begin
                lvk      = 32'(lv) & cfg_mask[k];
                m_cnt[k] = (lvk > mx) ? mx : lvk;
                m_tc[k]  = 0;
                if (clr) begin m_ovf[k] = 0; m_unf[k] = 0; end
            end else begin
                m_tc[k] = 0;
                if (clr) begin m_ovf[k] = 0; m_unf[k] = 0; end
                if (stp && updn) begin
                    if (m_cnt[k] + st <= mx) m_cnt[k] = m_cnt[k] + st;
                    else begin
                        m_cnt[k] = cfg_sat[k] ? mx : (m_cnt[k] + st) % (mx + 1);
                        m_tc[k]  = 1; m_ovf[k] = 1;
                    end
                end else if (stp) begin
                    if (m_cnt[k] >= st) m_cnt[k] = m_cnt[k] - st;
                    else begin
                        m_cnt[k] = cfg_sat[k] ? 0 : m_cnt[k] + (mx + 1) - st;
                        m_tc[k]  = 1; m_unf[k] = 1;
                    end
                end
            end
            e.idx  = k;        e.cnt = m_cnt[k];  e.tc = m_tc[k];
            e.ovf  = m_ovf[k]; e.unf = m_unf[k];
            e.amax = (m_cnt[k] == mx);
            e.amin = (m_cnt[k] == 0);
            sb.push_back(e);
        end
    endtask

    // Apply one cycle of inputs, record expectations, wait to the next negedge.
    task automatic cyc(bit r, bit ld, logic [15:0] v, bit ud, bit in, bit cl);
        rst = r; load = ld; lv = v; updn = ud; inc = in; clr = cl;
        model_and_push();
        @(negedge clk);
    endtask

    task automatic chk(string nm, int unsigned act, int unsigned exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic exp_t get_act(int k);
        exp_t a;
        a.idx = k;
        case (k)
            0:       a.cnt = 32'(cnt_a);
            1:       a.cnt = 32'(cnt_b);
            2:       a.cnt = 32'(cnt_c);
            3:       a.cnt = 32'(cnt_d);
            default: a.cnt = 32'(cnt_e);
        endcase
        a.tc   = tc_w[k];   a.ovf  = ovf_w[k];  a.unf = unf_w[k];
        a.amax = amax_w[k]; a.amin = amin_w[k];
        return a;
    endfunction

    // Monitor: after every rising edge, compare each queued expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            while (sb.size() > 0) begin
                exp_t e, a;
                e = sb.pop_front();
                a = get_act(e.idx);
                n_checks++;
                if (a.cnt == e.cnt && a.tc == e.tc && a.ovf == e.ovf && a.unf == e.unf &&
                    a.amax == e.amax && a.amin == e.amin) begin
                    n_pass++;
                end else begin
                    $display("FAIL sb dut%0d t=%0t: got cnt=%0d tc=%0b ovf=%0b unf=%0b max=%0b min=%0b expected cnt=%0d tc=%0b ovf=%0b unf=%0b max=%0b min=%0b",
                             e.idx, $time, a.cnt, a.tc, a.ovf, a.unf, a.amax, a.amin,
                             e.cnt, e.tc, e.ovf, e.unf, e.amax, e.amin);
                end
            end
        end
    end

    initial begin
        // Reset state and basic edge-qualified counting
        cyc(1, 0, 0, 1, 0, 0);
        chk("reset count", 32'(cnt_a), 0);
        chk("reset tc/ovf/unf", {29'd0, tc_w[0], ovf_w[0], unf_w[0]}, 0);
        repeat (3) begin cyc(0, 0, 0, 1, 1, 0); cyc(0, 0, 0, 1, 0, 0); end
        chk("three up pulses", 32'(cnt_a), 3);
        repeat (4) cyc(0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("held inc edge mode", 32'(cnt_a), 4);
        chk("held inc level mode", 32'(cnt_e), 7);
        cyc(0, 0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 0, 0);
        chk("down pulse", 32'(cnt_a), 3);

        // Wrap at 9 with terminal pulse and sticky flags
        cyc(0, 1, 9, 1, 0, 0);
        cyc(0, 0, 0, 1, 1, 0);
        chk("wrap up count", 32'(cnt_b), 0);
        chk("wrap up tc", 32'(tc_w[1]), 1);
        chk("wrap up ovf", 32'(ovf_w[1]), 1);
        cyc(0, 0, 0, 1, 0, 0);
        chk("tc one cycle", 32'(tc_w[1]), 0);
        cyc(0, 0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 0, 0);
        chk("wrap down count", 32'(cnt_b), 9);
        chk("wrap down unf", 32'(unf_w[1]), 1);
        cyc(0, 0, 0, 1, 0, 1);
        chk("clr flags", {30'd0, ovf_w[1], unf_w[1]}, 0);

        // Saturate mode: repeated requests at the clamp keep pulsing tc
        cyc(0, 1, 8, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 1, 0);
            chk("sat up count", 32'(cnt_c), 9);
            chk("sat up tc", 32'(tc_w[2]), (i > 0) ? 1 : 0);
            cyc(0, 0, 0, 1, 0, 0);
        end
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("sat down count", 32'(cnt_c), 0);
        chk("sat down unf", 32'(unf_w[2]), 1);
        cyc(0, 0, 0, 0, 0, 0);

        // Step of 3 wrapping both ways
        cyc(0, 1, 8, 1, 0, 0);
        cyc(0, 0, 0, 1, 1, 0); chk("step3 up wrap", 32'(cnt_d), 1);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0); chk("step3 down wrap", 32'(cnt_d), 8);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 2, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0); chk("step3 down to max", 32'(cnt_d), 9);
        chk("step3 at_max", 32'(amax_w[3]), 1);
        cyc(0, 0, 0, 0, 0, 0);

        // Priority: rst > load > step; load clamps; set beats clear
        cyc(1, 1, 5, 1, 1, 0); chk("rst beats load", 32'(cnt_a), 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 1, 5, 1, 1, 0); chk("load beats step", 32'(cnt_a), 5);
        cyc(0, 0, 0, 1, 0, 0); chk("load step discarded", 32'(cnt_a), 5);
        cyc(0, 1, 12, 1, 0, 0);
        chk("load clamp", 32'(cnt_b), 9);
        chk("load no clamp wide", 32'(cnt_a), 12);
        cyc(0, 0, 0, 1, 0, 1); chk("pre-clear ovf", 32'(ovf_w[1]), 0);
        cyc(0, 0, 0, 1, 1, 1); chk("set beats clear", 32'(ovf_w[1]), 1);
        cyc(0, 0, 0, 1, 0, 0);

        // inc held through reset release gives no edge-mode step
        cyc(0, 1, 5, 1, 0, 0);
        cyc(1, 0, 0, 1, 1, 0); chk("rst with inc", 32'(cnt_a), 0);
        cyc(0, 0, 0, 1, 1, 0); cyc(0, 0, 0, 1, 1, 0);
        chk("no step after rst", 32'(cnt_a), 0);
        chk("level after rst", 32'(cnt_e), 2);
        cyc(0, 0, 0, 1, 0, 0); cyc(0, 0, 0, 1, 1, 0);
        chk("fresh edge", 32'(cnt_a), 1);
        repeat (3) cyc(0, 0, 0, 1, 1, 0);
        chk("level three cycles", 32'(cnt_e), 6);
        cyc(0, 0, 0, 1, 0, 0);

        // Randomized traffic, biased toward boundary load values
        for (int i = 0; i < 600; i++) begin
            bit          r, ld, cl, ud, in;
            logic [15:0] v;
            int unsigned sel;
            r   = ($urandom_range(0, 49) == 0);
            ld  = ($urandom_range(0, 9) == 0);
            cl  = !ld && ($urandom_range(0, 9) == 0);
            ud  = 1'($urandom_range(0, 1));
            in  = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 2);
            if (sel == 0)      v = 16'($urandom);
            else if (sel == 1) v = 16'hFFFF - 16'($urandom_range(0, 2));
            else               v = 16'($urandom_range(0, 15));
            cyc(r, ld, v, ud, in, cl);
        end

        chk("scoreboard drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
